// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core control path: stage codes and sequencer defaults.
package core_ctrl_pkg;

    localparam int STAGE_W = 3;

    // Default number of MEMORY cycles allowed before declaring a data-memory timeout.
    localparam int DEFAULT_MEM_TIMEOUT = 16;

    typedef enum logic [STAGE_W-1:0] {
        STAGE_FETCH     = 3'd0,
        STAGE_DECODE    = 3'd1,
        STAGE_EXECUTE   = 3'd2,
        STAGE_MEMORY    = 3'd3,
        STAGE_WRITEBACK = 3'd4,
        STAGE_HALTED    = 3'd5
    } stage_t;

endpackage

// File: rtl/seq_perf_counters.sv
// Free-running cycle and retired-instruction counters for stage_sequencer.
// Only compiled when STAGE_SEQ_PERF_EN is defined; both counters wrap modulo 2^CNT_W.
`ifdef STAGE_SEQ_PERF_EN
module seq_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_instret,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    // Slot 0 counts every cycle out of reset, slot 1 counts retirements.
    logic [1:0]            inc;
    logic [1:0][CNT_W-1:0] count;

    assign inc = {inc_instret, 1'b1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] count_reg;

            // Wrapping counter, cleared by reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (inc[gi]) begin
                    count_reg <= count_reg + 1'b1;
                end
            end

            assign count[gi] = count_reg;
        end
    endgenerate

    assign cycle_count   = count[0];
    assign instret_count = count[1];

endmodule
`endif

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: walks each instruction through FETCH, DECODE,
// EXECUTE, optional MEMORY and WRITEBACK, with memory-wait stalls, a
// data-memory timeout and halt/resume control.
// Optional performance counters are built when STAGE_SEQ_PERF_EN is defined;
// otherwise cycle_count and instret_count are tied to zero.
module stage_sequencer
    import core_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_mem_ready,
    input  logic               data_mem_ready,
    input  logic               mem_access,
    input  logic               halt_req,
    input  logic               resume,
    output logic               IF_kick_up,
    output logic               ID_kick_up,
    output logic               EX_kick_up,
    output logic               MEM_kick_up,
    output logic               WB_kick_up,
    output logic [STAGE_W-1:0] stage,
    output logic               halted,
    output logic               mem_error,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   instret_count
);

    // The wait counter only ever needs to hold MEM_TIMEOUT-1; with the timeout
    // disabled it simply wraps and is never consulted.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

    stage_t            state_reg;
    logic              entry_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              mem_error_reg;
    logic              timeout_hit;

    // The current MEMORY cycle is the last one allowed without data.
    assign timeout_hit = TIMEOUT_EN && (wait_cnt_reg == WAIT_LAST);

    // Stage FSM: entry_reg is raised on every state change and dropped while stalling.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= STAGE_FETCH;
            entry_reg     <= 1'b1;
            wait_cnt_reg  <= '0;
            mem_error_reg <= 1'b0;
        end else begin
            case (state_reg)
                STAGE_FETCH: begin
                    if (inst_mem_ready) begin
                        state_reg <= STAGE_DECODE;
                        entry_reg <= 1'b1;
                    end else begin
                        entry_reg <= 1'b0;
                    end
                end
                STAGE_DECODE: begin
                    state_reg <= STAGE_EXECUTE;
                    entry_reg <= 1'b1;
                end
                STAGE_EXECUTE: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= mem_access ? STAGE_MEMORY : STAGE_WRITEBACK;
                    entry_reg    <= 1'b1;
                end
                STAGE_MEMORY: begin
                    // Data arriving in the final allowed cycle still completes the access.
                    if (data_mem_ready) begin
                        state_reg <= STAGE_WRITEBACK;
                        entry_reg <= 1'b1;
                    end else if (timeout_hit) begin
                        state_reg     <= STAGE_HALTED;
                        entry_reg     <= 1'b1;
                        mem_error_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        entry_reg    <= 1'b0;
                    end
                end
                STAGE_WRITEBACK: begin
                    state_reg <= halt_req ? STAGE_HALTED : STAGE_FETCH;
                    entry_reg <= 1'b1;
                end
                STAGE_HALTED: begin
                    // A timed-out core stays parked until reset.
                    if (resume && !mem_error_reg) begin
                        state_reg <= STAGE_FETCH;
                        entry_reg <= 1'b1;
                    end else begin
                        entry_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= STAGE_FETCH;
                    entry_reg <= 1'b1;
                end
            endcase
        end
    end

    assign IF_kick_up  = (state_reg == STAGE_FETCH) && entry_reg;
    assign ID_kick_up  = (state_reg == STAGE_DECODE);
    assign EX_kick_up  = (state_reg == STAGE_EXECUTE);
    assign MEM_kick_up = (state_reg == STAGE_MEMORY) && entry_reg;
    assign WB_kick_up  = (state_reg == STAGE_WRITEBACK);
    assign stage       = state_reg;
    assign halted      = (state_reg == STAGE_HALTED);
    assign mem_error   = mem_error_reg;

`ifdef STAGE_SEQ_PERF_EN
    seq_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk          (clk),
        .reset        (reset),
        .inc_instret  (WB_kick_up),
        .cycle_count  (cycle_count),
        .instret_count(instret_count)
    );
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule
